// File: rtl/wb_mem_pkg.sv
// Shared types and default widths for the wishbone memory responder.
package wb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        RETRY = 2'd3
    } wb_mem_state_t;

    localparam int WB_DATA_W = 128;
    localparam int WB_ADR_W  = 28;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

endpackage

// File: rtl/wishbone.sv
// Line-wide wishbone bus carrying the cache-master requests and the memory response.
interface wishbone #(
    parameter int DATA_W = wb_mem_pkg::WB_DATA_W,
    parameter int ADR_W  = wb_mem_pkg::WB_ADR_W
) (
    input logic CLK
);
    logic                  CYC;
    logic                  STB;
    logic                  WE;
    logic [ADR_W-1:0]      ADR;
    logic [DATA_W/8-1:0]   SEL;
    logic [DATA_W-1:0]     DAT_M;
    logic [DATA_W-1:0]     DAT_S;
    logic                  ACK;
    logic                  RTY;

    modport master (
        input  CLK,
        output CYC, STB, WE, ADR, SEL, DAT_M,
        input  DAT_S, ACK, RTY
    );

    modport slave (
        input  CLK,
        input  CYC, STB, WE, ADR, SEL, DAT_M,
        output DAT_S, ACK, RTY
    );
endinterface

// File: rtl/wb_mem_array.sv
// Single-port, byte-enabled line store with a registered read port and no reset.
module wb_mem_array #(
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Read-during-write returns the old line; the responder never needs the bypass.
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone memory responder: one outstanding request, programmable ACK latency,
// RTY for lines beyond the backing store.
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADR_W      = WB_ADR_W,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    wishbone.slave        wb,
    output wb_mem_state_t dbg_state
);
    localparam int SEL_W = DATA_W / 8;

    wb_mem_state_t         state, state_nxt;
    logic [7:0]            cnt_q, cnt_nxt;
    logic [DEPTH_LOG2-1:0] adr_q;
    logic                  we_q;
    logic [SEL_W-1:0]      sel_q;
    logic [DATA_W-1:0]     dat_m_q;
    logic [DATA_W-1:0]     dat_s_q;
    logic [DATA_W-1:0]     rdata;
    logic                  req, in_range, accept, rd_resp;
    logic [DEPTH_LOG2-1:0] arr_addr;

    // Handshake: a request is CYC & STB sampled in IDLE; it completes with a
    // single-cycle ACK (or RTY), and must stay asserted through WAIT or it aborts.
    assign req      = wb.CYC & wb.STB;
    assign in_range = (wb.ADR[ADR_W-1:DEPTH_LOG2] == '0);
    assign rd_resp  = (state == RESP) && !we_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_nxt = 8'(LATENCY - 1);
                    if (!in_range)         state_nxt = RETRY;
                    else if (LATENCY == 1) state_nxt = RESP;
                    else                   state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            RETRY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_m_q <= '0;
            dat_s_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (accept) begin
                adr_q   <= wb.ADR[DEPTH_LOG2-1:0];
                we_q    <= wb.WE;
                sel_q   <= wb.SEL;
                dat_m_q <= wb.DAT_M;
            end
            if (rd_resp) dat_s_q <= rdata;
        end
    end

    // In IDLE the live address feeds the array so a LATENCY of 1 has read data in RESP.
    assign arr_addr = (state == IDLE) ? wb.ADR[DEPTH_LOG2-1:0] : adr_q;

    wb_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .CLK   (CLK),
        .we    ((state == RESP) && we_q),
        .sel   (sel_q),
        .addr  (arr_addr),
        .wdata (dat_m_q),
        .rdata (rdata)
    );

    assign wb.ACK    = (state == RESP);
    assign wb.RTY    = (state == RETRY);
    assign wb.DAT_S  = rd_resp ? rdata : dat_s_q;
    assign dbg_state = state;
endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Wishbone responder that terminates the instruction and data buses driven by the cache masters: a byte-enabled line-wide backing store with programmable access latency, single outstanding transaction, and RETRY signalling for out-of-range addresses. It sits on the far side of `ibus`/`dbus` in the simulation top level and serves as the reference memory for CPU and cache verification.

## Interface
- `DATA_W`, 128: line width in bits, the same width as the bus `DAT_M`/`DAT_S`.
- `ADR_W`, 28: bus line-address width.
- `DEPTH_LOG2`, 12: log2 of the number of stored lines; lines at `ADR >= 2**DEPTH_LOG2` are out of range.
- `LATENCY`, 4: cycles from request acceptance to `ACK`; legal range 1..255.
- `CLK` input, 1 bit: bus clock, the same `CLK` carried by the wishbone interface.
- `RST_N` input, 1 bit: asynchronous, active-low reset.
- `wb`, `wishbone.slave` modport:
  - `CYC`, `STB`, `WE` in, 1 bit each.
  - `ADR` in, `ADR_W` bits.
  - `SEL` in, `DATA_W/8` bits.
  - `DAT_M` in, `DATA_W` bits.
  - `DAT_S` out, `DATA_W` bits.
  - `ACK`, `RTY` out, 1 bit each.

## Operation
- FSM states are `IDLE`, `WAIT`, `RESP` and `RETRY`.
- **IDLE**
  - On `CYC & STB`, latch `ADR`, `WE`, `SEL` and `DAT_M`, then load the counter with `LATENCY-1`.
  - If the address is out of range, go to `RETRY`.
  - Otherwise go to `WAIT`, or straight to `RESP` when `LATENCY == 1`.
- **WAIT**
  - Decrement the counter each cycle; go to `RESP` when it reaches 0.
  - If `CYC` or `STB` is low in any `WAIT` cycle, abort to `IDLE`. An aborted transaction produces no array write and no `ACK`.
- **RESP**
  - `ACK = 1` for exactly one cycle.
  - Read: `DAT_S` carries the array line at the latched address.
  - Write: each byte `i` with `SEL[i] = 1` takes `DAT_M` byte `i`; bytes with `SEL[i] = 0` keep their contents. The commit happens on the clock edge that ends the `RESP` cycle.
  - Always return to `IDLE` after `RESP`.
- **RETRY**
  - `RTY = 1` for one cycle, no array access, `DAT_S` holds its previous value; then return to `IDLE`.
- The latched request is authoritative. Changes to `ADR`, `WE`, `SEL` or `DAT_M` after acceptance are ignored.
- `DAT_S` is registered and is only updated in `RESP` for reads. It holds its value otherwise, including after writes.
- Array contents are not reset and are initialised only by the bench.

## Timing
- Reset values: `ACK = 0`, `RTY = 0`, `DAT_S = 0`, state `IDLE`, counter 0.
  - Asserting `RST_N` low forces these values asynchronously, including in the middle of a transaction.
  - A write whose `RESP` edge has not yet occurred is dropped.
- Latency: a request accepted at edge `t` sees `ACK` high in the cycle after edge `t+LATENCY-1`. `LATENCY == 1` gives `ACK` in the cycle immediately after acceptance.
- Back-to-back requests:
  - The cycle in which `ACK` or `RTY` is high is never an accept cycle.
  - The earliest next acceptance is the following cycle, in `IDLE`, if `CYC & STB` is still high. So the minimum spacing between accepted requests is `LATENCY + 1` cycles.
- `ACK` and `RTY` are mutually exclusive and never high in consecutive cycles.
- Read-after-write to the same line with back-to-back transactions returns the newly written bytes.
- Address range check uses `ADR[ADR_W-1:DEPTH_LOG2] != 0`. `ADR` wrap-around is not supported.

## Structure
- Package `wb_mem_pkg` holds:
  - the state enum `wb_mem_state_t` (`IDLE`, `WAIT`, `RESP`, `RETRY`);
  - the default width constants `WB_DATA_W` and `WB_ADR_W`;
  - the derived constant `WB_SEL_W = WB_DATA_W/8`.
- One sub-module, `wb_mem_array`: synchronous, byte-enabled, single-port line array.
  - Inputs: `CLK`, `we`, `sel`, `addr`, `wdata`.
  - Output: registered `rdata`.
  - No reset.
- The FSM, counter and request latch live in `wb_mem_responder`.

## Test plan
- **Reset:**
  - Stimulus: hold `RST_N = 0` for 3 cycles while `CYC = STB = 1`.
  - Required: `ACK = RTY = 0` and `DAT_S = 0` throughout; the first `ACK` appears `LATENCY` cycles after release.
- **Latency sweep:**
  - Stimulus: `LATENCY` in {1, 4}; write line `0x10` with all bytes, then read it.
  - Required: `ACK` at exactly 1 and 4 cycles after each acceptance; read data matches the write.
- **Byte enables:**
  - Stimulus: preload line `0x20 = 0`; write `DAT_M = all 0xFF` with `SEL = 16'h00F0`.
  - Required: a read returns `0xFF` in bytes 4..7 and `0x00` in every other byte.
- **Abort:**
  - Stimulus: start a write to `0x30`, then drop `STB` in the second `WAIT` cycle.
  - Required: no `ACK`; a subsequent read of `0x30` returns the old contents.
- **Out of range:**
  - Stimulus: read at `ADR = 2**DEPTH_LOG2`.
  - Required: `RTY` for one cycle, `ACK` never asserted, `DAT_S` unchanged.
- **Back-to-back plus reset mid-wait:**
  - Stimulus: keep `STB` high across two reads.
  - Required: the second acceptance happens in the cycle after `ACK`.
  - Stimulus: then reset in the middle of a `WAIT`.
  - Required: `ACK` is never issued for the interrupted request.
